// File: rtl/clk_switch_pkg.sv
// Shared definitions for the clock-switch sequencer and the clk_mux wrapper.
// Holds the sequencer state encodings and the default gate-off/settle durations.
package clk_switch_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OFF    = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_OFF    = ST_OFF,
        S_SWITCH = ST_SWITCH,
        S_SETTLE = ST_SETTLE
    } state_t;

    localparam int DEF_GATE_OFF_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES   = 4;

endpackage

// File: rtl/clk_sw_dncnt.sv
// Loadable down-counter with a zero flag; shared by the gate-off and settle waits.
// Load wins over enable, and the count holds at zero.
module clk_sw_dncnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-switch sequencer: gates the muxed clock off, moves clk_mux sel, waits
// for the new source to settle, then reopens the gate. Runs on an always-on clock.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int NUM_INPUTS      = 2,
    parameter int SEL_W           = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int DEFAULT_SEL     = 0,
    parameter int GATE_OFF_CYCLES = DEF_GATE_OFF_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [SEL_W-1:0]      req_sel,
    output logic                  req_ready,
    input  logic [NUM_INPUTS-1:0] clk_ok,
    output logic [SEL_W-1:0]      mux_sel,
    output logic                  clk_gate_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Handshake: a request transfers on a clk edge with req_valid && req_ready;
    // req_ready is high only in IDLE and out of reset, and the requester holds
    // req_valid/req_sel stable until the transfer happens.

    state_t           state, state_n;
    logic [SEL_W-1:0] target, target_n;
    logic [SEL_W-1:0] mux_sel_n;
    logic             gate_n, busy_n, done_n, err_n;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             req_ok, target_ok;

    // Out-of-range indices never match a loop index, so they read as unhealthy.
    always_comb begin
        req_ok    = 1'b0;
        target_ok = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (req_sel == SEL_W'(i)) req_ok    = clk_ok[i];
            if (target  == SEL_W'(i)) target_ok = clk_ok[i];
        end
    end

    clk_sw_dncnt #(.CNT_W(CNT_W)) u_dncnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            target      <= SEL_W'(DEFAULT_SEL);
            mux_sel     <= SEL_W'(DEFAULT_SEL);
            clk_gate_en <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            target      <= target_n;
            mux_sel     <= mux_sel_n;
            clk_gate_en <= gate_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        target_n  = target;
        mux_sel_n = mux_sel;
        gate_n    = clk_gate_en;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (!req_ok) begin
                        err_n = 1'b1;
                    end else if (req_sel == mux_sel) begin
                        done_n = 1'b1;
                    end else begin
                        target_n = req_sel;
                        state_n  = S_OFF;
                        gate_n   = 1'b0;
                        busy_n   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(GATE_OFF_CYCLES - 1);
                    end
                end
            end
            S_OFF: begin
                // Losing the target clock while still gated off aborts cleanly.
                if (!target_ok) begin
                    state_n = S_IDLE;
                    gate_n  = 1'b1;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                end else if (cnt_zero) begin
                    state_n   = S_SWITCH;
                    mux_sel_n = target;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_SWITCH: begin
                state_n  = S_SETTLE;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
            end
            S_SETTLE: begin
                if (cnt_zero) begin
                    state_n = S_IDLE;
                    gate_n  = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state == S_IDLE) && !rst;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with default parameters and a 10 ns clock.
// Expected values are hand-derived edge counts relative to the accept edge e0.
module tb_clk_switch_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [0:0] req_sel;
    logic       req_ready;
    logic [1:0] clk_ok;
    logic [0:0] mux_sel;
    logic       clk_gate_en;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [0:0] prev_sel = 1'b0;
    logic       prev_rst = 1'b1;

    clk_switch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .clk_ok      (clk_ok),
        .mux_sel     (mux_sel),
        .clk_gate_en (clk_gate_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse counters and the gate/select safety checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (!rst && !prev_rst)
            check("gate_vs_sel", {31'd0, clk_gate_en && (mux_sel != prev_sel)}, 32'd0);
        prev_sel = mux_sel;
        prev_rst = rst;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0, e0c, lat;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        clk_ok    = 2'b11;

        // 1. reset values while rst is held
        #12;
        check("rst_mux_sel", mux_sel, 0);
        check("rst_gate", clk_gate_en, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_done_err", {done, err}, 0);
        step(1);
        rst = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);
        step(1);

        // 3. same-select request completes at once
        d0 = done_cnt;
        req_valid = 1'b1; req_sel = 1'b0;
        step(1);
        req_valid = 1'b0;
        check("same_done", done, 1);
        check("same_gate", clk_gate_en, 1);
        check("same_busy", busy, 0);
        step(1);
        check("same_done_clr", done, 0);
        check("same_one_done", done_cnt - d0, 1);

        // 4. reject: target clock not healthy
        clk_ok = 2'b01;
        e0c = err_cnt;
        req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("rej_err", err, 1);
        check("rej_done", done, 0);
        check("rej_mux_sel", mux_sel, 0);
        check("rej_gate", clk_gate_en, 1);
        check("rej_busy", busy, 0);
        step(1);
        check("rej_err_clr", err, 0);
        check("rej_one_err", err_cnt - e0c, 1);
        clk_ok = 2'b11;

        // 2. full switch 0->1
        d0 = done_cnt;
        req_valid = 1'b1; req_sel = 1'b1;
        check("sw_ready", req_ready, 1);
        step(1);
        req_valid = 1'b0;
        check("sw_e0_gate", clk_gate_en, 0);
        check("sw_e0_busy", busy, 1);
        check("sw_e0_ready", req_ready, 0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("sw_busy_e%0d", k), busy, 1);
            check($sformatf("sw_gate_e%0d", k), clk_gate_en, 0);
            check($sformatf("sw_done_e%0d", k), done, 0);
            check($sformatf("sw_sel_e%0d", k), mux_sel, (k >= 4) ? 1 : 0);
        end
        step(1);
        check("sw_e9_done", done, 1);
        check("sw_e9_gate", clk_gate_en, 1);
        check("sw_e9_busy", busy, 0);
        check("sw_e9_sel", mux_sel, 1);
        step(1);
        check("sw_done_clr", done, 0);
        check("sw_one_done", done_cnt - d0, 1);

        // asynchronous reset mid-cycle reverts the select immediately
        #3;
        rst = 1'b1;
        #1;
        check("arst_mux_sel", mux_sel, 0);
        check("arst_gate", clk_gate_en, 1);
        check("arst_ready", req_ready, 0);
        step(2);
        rst = 1'b0;
        step(1);

        // 5. abort when the target clock drops during OFF
        e0c = err_cnt;
        req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        req_valid = 1'b0;
        step(2);
        clk_ok = 2'b01;
        step(1);
        check("abort_err", err, 1);
        check("abort_gate", clk_gate_en, 1);
        check("abort_sel", mux_sel, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", req_ready, 1);
        clk_ok = 2'b11;
        req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("abort_reaccept", busy, 1);
        check("abort_one_err", err_cnt - e0c, 1);
        lat = 0;
        while (!done && lat < 30) begin
            step(1);
            lat++;
        end
        check("reaccept_latency", lat, 9);
        check("reaccept_sel", mux_sel, 1);
        step(1);

        // 6. held request while busy, then reset mid-sequence
        req_valid = 1'b1; req_sel = 1'b0;
        step(1);
        req_sel = 1'b1;
        check("hold_busy", busy, 1);
        check("hold_ready", req_ready, 0);
        lat = 0;
        while (!done && lat < 30) begin
            step(1);
            lat++;
            if (!done) check($sformatf("hold_not_ready_%0d", lat), req_ready, 0);
        end
        check("hold_latency", lat, 9);
        check("hold_sel0", mux_sel, 0);
        check("hold_ready_at_done", req_ready, 1);
        step(1);
        req_valid = 1'b0;
        check("hold_accepted", busy, 1);
        check("hold_gate_off", clk_gate_en, 0);
        step(6);
        check("pre_rst_sel", mux_sel, 1);
        check("pre_rst_gate", clk_gate_en, 0);
        d0 = done_cnt; e0c = err_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_sel", mux_sel, 0);
        check("mid_rst_gate", clk_gate_en, 1);
        check("mid_rst_busy", busy, 0);
        step(2);
        rst = 1'b0;
        step(12);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_err", err_cnt - e0c, 0);
        check("mid_rst_idle_sel", mux_sel, 0);
        check("mid_rst_idle_gate", clk_gate_en, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
